// File: rtl/imem_arbiter.sv
// Arbiter sharing one single-port instruction RAM between fetch (read-only) and loader (read/write).
// Holds fetch off in BOOT until boot_done, then round-robins with a starvation guard.
module imem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int MAX_WAIT = 4,
  parameter bit BOOT_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [31:0]       f_rdata,
  output logic              f_err,
  output logic              f_hold,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [31:0]       l_addr,
  input  logic [31:0]       l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [31:0]       l_rdata,
  output logic              l_err,
  input  logic              boot_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  localparam logic [0:0] ST_BOOT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

  logic [0:0]    state;
  logic          last_l;
  logic [CW-1:0] f_wait;
  logic [CW-1:0] l_wait;
  logic          resp_valid;
  logic          resp_loader;
  logic          resp_err;
  logic          resp_rd;
  logic          f_sel;
  logic          l_sel;
  logic          f_mis;
  logic          l_mis;
  logic [31:0]   sel_addr;

  assign f_mis = (f_addr[1:0] != 2'b00);
  assign l_mis = (l_addr[1:0] != 2'b00);

  // Grant decision; everything is forced quiet while reset is asserted.
  always_comb begin
    f_sel = 1'b0;
    l_sel = 1'b0;
    if (rst_n) begin
      if (state == ST_BOOT) begin
        l_sel = l_req;
      end else if (f_req && l_req) begin
        if (f_wait == WAIT_MAX && l_wait != WAIT_MAX) f_sel = 1'b1;
        else if (l_wait == WAIT_MAX && f_wait != WAIT_MAX) l_sel = 1'b1;
        else if (last_l) f_sel = 1'b1;
        else l_sel = 1'b1;
      end else begin
        f_sel = f_req;
        l_sel = l_req;
      end
    end
  end

  assign sel_addr  = l_sel ? l_addr : f_addr;
  assign f_gnt     = f_sel;
  assign l_gnt     = l_sel;
  assign mem_en    = f_sel | l_sel;
  assign mem_we    = l_sel & l_we & ~l_mis;
  assign mem_addr  = mem_en ? sel_addr[ADDR_W+1:2] : '0;
  assign mem_wdata = l_sel ? l_wdata : 32'h0;
  assign f_hold    = rst_n ? (state == ST_BOOT) : BOOT_EN;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= BOOT_EN ? ST_BOOT : ST_RUN;
      last_l      <= 1'b0;
      f_wait      <= '0;
      l_wait      <= '0;
      resp_valid  <= 1'b0;
      resp_loader <= 1'b0;
      resp_err    <= 1'b0;
      resp_rd     <= 1'b0;
    end else begin
      if (state == ST_BOOT && boot_done) state <= ST_RUN;
      if (f_sel) last_l <= 1'b0;
      else if (l_sel) last_l <= 1'b1;

      if (state == ST_BOOT || !f_req || f_sel) f_wait <= '0;
      else if (f_wait != WAIT_MAX) f_wait <= f_wait + CW'(1);

      if (!l_req || l_sel) l_wait <= '0;
      else if (l_wait != WAIT_MAX) l_wait <= l_wait + CW'(1);

      resp_valid  <= mem_en;
      resp_loader <= l_sel;
      resp_err    <= l_sel ? l_mis : (f_sel & f_mis);
      resp_rd     <= (f_sel & ~f_mis) | (l_sel & ~l_we & ~l_mis);
    end
  end

  // Response path: data only for aligned reads, zero for write acks and errors.
  assign f_rvalid = rst_n & resp_valid & ~resp_loader;
  assign l_rvalid = rst_n & resp_valid & resp_loader;
  assign f_err    = f_rvalid & resp_err;
  assign l_err    = l_rvalid & resp_err;
  assign f_rdata  = (f_rvalid & resp_rd) ? mem_rdata : 32'h0;
  assign l_rdata  = (l_rvalid & resp_rd) ? mem_rdata : 32'h0;
endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a behavioural 256x32 synchronous RAM attached.
module tb_imem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt, f_rvalid, f_err, f_hold;
  logic [31:0] f_rdata;
  logic        l_req, l_we;
  logic [31:0] l_addr, l_wdata;
  logic        l_gnt, l_rvalid, l_err;
  logic [31:0] l_rdata;
  logic        boot_done;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  logic [31:0] ram [0:255];

  always #5 clk = ~clk;

  imem_arbiter #(.ADDR_W(8), .MAX_WAIT(4), .BOOT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_rdata(f_rdata), .f_err(f_err), .f_hold(f_hold),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata), .l_err(l_err),
    .boot_done(boot_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nx();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    mem_rdata = 32'h0;
    rst_n = 1'b0; f_req = 1'b1; f_addr = 32'h0;
    l_req = 1'b0; l_we = 1'b0; l_addr = 32'h0; l_wdata = 32'h0; boot_done = 1'b0;
    nx(); nx();
    @(negedge clk);
    chk("rst_f_hold", f_hold, 1);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_f_rvalid", f_rvalid, 0);
    $display("reset: f_hold=%0b mem_en=%0b", f_hold, mem_en);
    nx();

    // 1: BOOT blocks fetch
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("boot_f_gnt", f_gnt, 0);
      chk("boot_f_hold", f_hold, 1);
      chk("boot_mem_en", mem_en, 0);
      $display("boot cyc %0d: f_gnt=%0b f_hold=%0b", i, f_gnt, f_hold);
      nx();
    end

    // 2: load program, leave BOOT, fetch @0x4
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h0; l_wdata = 32'h0000_0013;
    @(negedge clk);
    chk("ld0_l_gnt", l_gnt, 1);
    chk("ld0_mem_we", mem_we, 1);
    chk("ld0_mem_addr", mem_addr, 0);
    chk("ld0_f_gnt", f_gnt, 0);
    $display("load @0: l_gnt=%0b mem_we=%0b", l_gnt, mem_we);
    nx();
    l_addr = 32'h4; l_wdata = 32'h0050_0093;
    @(negedge clk);
    chk("ld0_l_rvalid", l_rvalid, 1);
    chk("ld0_l_rdata", l_rdata, 0);
    chk("ld0_l_err", l_err, 0);
    chk("ld1_mem_addr", mem_addr, 1);
    $display("load @4: l_gnt=%0b ack=%0b", l_gnt, l_rvalid);
    nx();
    l_req = 1'b0; l_we = 1'b0; boot_done = 1'b1; f_addr = 32'h4;
    @(negedge clk);
    chk("bd_f_gnt", f_gnt, 0);
    chk("ld1_l_rvalid", l_rvalid, 1);
    $display("boot_done: f_gnt=%0b", f_gnt);
    nx();
    boot_done = 1'b0;
    @(negedge clk);
    chk("run_f_gnt", f_gnt, 1);
    chk("run_f_hold", f_hold, 0);
    chk("run_mem_addr", mem_addr, 1);
    chk("run_mem_we", mem_we, 0);
    $display("fetch @4: f_gnt=%0b f_hold=%0b", f_gnt, f_hold);
    nx();
    f_req = 1'b0;
    @(negedge clk);
    chk("f4_rvalid", f_rvalid, 1);
    chk("f4_rdata", f_rdata, 32'h0050_0093);
    $display("fetch resp: rvalid=%0b rdata=%h", f_rvalid, f_rdata);
    nx();

    // 3: contention alternates, loader first (last grant was fetch)
    f_req = 1'b1; f_addr = 32'h4; l_req = 1'b1; l_we = 1'b0; l_addr = 32'h0;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) begin f_req = 1'b0; l_req = 1'b0; end
      @(negedge clk);
      if (i < 8) begin
        chk("rr_l_gnt", l_gnt, (i % 2 == 0));
        chk("rr_f_gnt", f_gnt, (i % 2 == 1));
      end
      if (i > 0) begin
        chk("rr_l_rvalid", l_rvalid, ((i - 1) % 2 == 0));
        chk("rr_f_rvalid", f_rvalid, ((i - 1) % 2 == 1));
        chk("rr_l_rdata", l_rdata, ((i - 1) % 2 == 0) ? 32'h0000_0013 : 32'h0);
        chk("rr_f_rdata", f_rdata, ((i - 1) % 2 == 1) ? 32'h0050_0093 : 32'h0);
      end
      $display("rr cyc %0d: l_gnt=%0b f_gnt=%0b l_rv=%0b f_rv=%0b", i, l_gnt, f_gnt, l_rvalid, f_rvalid);
      nx();
    end

    // 4: misaligned loader write then read-back
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h6; l_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("mis_l_gnt", l_gnt, 1);
    chk("mis_mem_we", mem_we, 0);
    chk("mis_mem_en", mem_en, 1);
    $display("misaligned write @6: l_gnt=%0b mem_we=%0b", l_gnt, mem_we);
    nx();
    l_we = 1'b0; l_addr = 32'h4;
    @(negedge clk);
    chk("mis_l_rvalid", l_rvalid, 1);
    chk("mis_l_err", l_err, 1);
    chk("mis_l_rdata", l_rdata, 0);
    $display("misaligned ack: err=%0b", l_err);
    nx();
    l_req = 1'b0;
    @(negedge clk);
    chk("rb_l_rvalid", l_rvalid, 1);
    chk("rb_l_err", l_err, 0);
    chk("rb_l_rdata", l_rdata, 32'h0050_0093);
    $display("read @4: rdata=%h", l_rdata);
    nx();

    // 5: address wrap
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h400; l_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("wrap_mem_addr", mem_addr, 0);
    chk("wrap_mem_we", mem_we, 1);
    $display("write @0x400: mem_addr=%0d", mem_addr);
    nx();
    l_req = 1'b0; l_we = 1'b0; f_req = 1'b1; f_addr = 32'h0;
    @(negedge clk);
    chk("wrap_f_gnt", f_gnt, 1);
    chk("wrap_f_addr", mem_addr, 0);
    nx();
    f_addr = 32'h2;
    @(negedge clk);
    chk("wrap_f_rdata", f_rdata, 32'hDEAD_BEEF);
    chk("fmis_f_gnt", f_gnt, 1);
    $display("fetch @0: rdata=%h", f_rdata);
    nx();
    f_req = 1'b0;
    @(negedge clk);
    chk("fmis_f_rvalid", f_rvalid, 1);
    chk("fmis_f_err", f_err, 1);
    chk("fmis_f_rdata", f_rdata, 0);
    $display("misaligned fetch: err=%0b", f_err);
    nx();

    // 6: reset drops in-flight response
    f_req = 1'b1; f_addr = 32'h4;
    @(negedge clk);
    chk("r6_f_gnt", f_gnt, 1);
    nx();
    rst_n = 1'b0;
    @(negedge clk);
    chk("r6_f_rvalid", f_rvalid, 0);
    chk("r6_f_gnt_rst", f_gnt, 0);
    chk("r6_f_hold", f_hold, 1);
    $display("reset mid-flight: f_rvalid=%0b", f_rvalid);
    nx();
    rst_n = 1'b1;
    @(negedge clk);
    chk("r6_boot_f_gnt", f_gnt, 0);
    chk("r6_boot_f_hold", f_hold, 1);
    chk("r6_boot_f_rvalid", f_rvalid, 0);
    $display("after reset: f_gnt=%0b f_hold=%0b", f_gnt, f_hold);
    nx();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
